memory_array: RTL and testbench
===============================

// Module: memory_array
// PURPOSE
//  - Small synchronous single-port register-file memory: l words of (w+1) bits.
//  - One clocked port does either a write or a read per cycle, selected by wrt_read.
//  - Read data is registered on out.
//  - Scratch or config storage inside a datapath.
// PARAMETERS
//  - w  7   MSB index of a data word; data width = w+1 (8 bits at default)
//  - l  10  number of words; legal range 1..16 (the address is 4 bits)
// PORTS
//  - clk       in   1    single clock; all sampling on the rising edge
//  - reset     in   1    asynchronous, active-low reset (0 = reset)
//  - wrt_read  in   1    operation select: 1 = write, 0 = read
//  - write     in   w+1  write data
//  - add       in   4    word address, 0..15
//  - enable    in   1    port enable; 0 = idle, nothing changes
//  - out       out  w+1  registered read data
// BEHAVIOUR
//  - Reset (reset==0):
//    - Immediately, without waiting for clk, clears all l words and out to 0.
//    - Held while reset is low; ports are ignored.
//    - Deassertion is synchronised to clk with a 2-flop synchroniser, so the
//      first active edge is the 2nd rising edge after reset goes high.
//  - Write (enable=1, wrt_read=1, add<l), on the rising edge:
//    - mem[add] <= write.
//    - out holds its previous value.
//  - Read (enable=1, wrt_read=0), on the rising edge:
//    - out <= mem[add] if add<l, else out <= 0.
//    - Latency is 1 cycle: data is valid after the edge that sampled add.
//  - Out-of-range write (add>=l): discarded; memory unchanged; no error flag.
//  - enable=0: memory and out hold, whatever the other inputs are.
//  - Read-after-write to the same address on back-to-back cycles returns the
//    new data; the write completes at edge N, the read samples at edge N+1.
//  - Every word never written since reset reads as 0.
//  - Single port, so a write and a read cannot happen in the same cycle.
//  - Reset asserted mid-operation: asynchronous clear wins over any edge in
//    progress.
//  - Storage is a flop array, not inferred SRAM, so the reset clear is possible.
//  - l=16 is legal: every address is in range and the range checks are
//    constant-true.
//  - Elaboration error if l<1 or l>16.
// STRUCTURE
//  - Shared package: localparam ADDR_W=4 and typedef of the operation encoding
//    (OP_READ=1'b0, OP_WRITE=1'b1).
//  - One sub-module is natural: memory_array_rst_sync, the 2-flop reset
//    synchroniser (async assert, sync deassert).
//  - Everything else stays flat: storage array, address range check, out
//    register.
// TESTING
//  - Clock period 4 ns.
//  1. Reset low, any inputs -> out=0 at once. After release, read addrs 0..9 ->
//     all 0.
//  2. Write 10@0, 33@3, 66@5, then read 0, 1, 3, 5 -> out = 10, 0, 33, 66, each
//     one cycle after its address.
//  3. Write 0xAA@9 then read 9 next cycle -> 0xAA. Write 0x55@12 (out of range),
//     then read 12 -> 0; read 2 -> unchanged.
//  4. enable=0 with wrt_read=1, write=0xFF, add=3 for several cycles -> mem[3]
//     unchanged (still 33) and out holds.
//  5. Pull reset low mid-sequence after test 2, between clock edges -> out=0
//     immediately; afterwards addrs 0, 3, 5 read back 0.
//  6. Release reset and issue a read on the 1st edge -> ignored; the 2nd edge
//     executes normally.

Source files
------------

// File: rtl/memory_array_pkg.sv
// Shared definitions for the memory_array register file.
//   ADDR_W    : width of the word address port
//   MAX_WORDS : largest word count the address can reach
//   op_e      : operation encoding carried on wrt_read
package memory_array_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/memory_array_rst_sync.sv
// Reset release synchroniser for memory_array.
// Asserts asynchronously with reset and releases through a two-stage flop chain.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset (0 = reset)
//   ready : high when the memory port may act on the current rising edge
module memory_array_rst_sync (
  input  logic clk,
  input  logic reset,
  output logic ready
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  // Stage 1 high means stage 2 rises on this edge. The port is allowed to act on
  // that edge, so the first active edge is the second one after release.
  assign ready = sync_q[0] | sync_q[1];

endmodule

// File: rtl/memory_array.sv
// Single-port register-file memory: l words of (w+1) bits, flop based.
// One operation per cycle (write or read, chosen by wrt_read) when enable is high.
// Ports:
//   clk      : clock, rising edge active
//   reset    : asynchronous active-low reset; clears all words and out at once
//   wrt_read : 1 = write, 0 = read
//   write    : write data
//   add      : word address; addresses >= l are out of range
//   enable   : port enable; 0 = memory and out hold
//   out      : registered read data (0 for an out-of-range read)
module memory_array
  import memory_array_pkg::*;
#(
  parameter int unsigned w = 7,
  parameter int unsigned l = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrt_read,
  input  logic [w:0]        write,
  input  logic [ADDR_W-1:0] add,
  input  logic              enable,
  output logic [w:0]        out
);

  if (l < 1 || l > MAX_WORDS) begin : g_bad_l
    $error("memory_array: l must be in 1..16");
  end

  logic [w:0] mem_q [l];
  logic [w:0] rd_data;
  logic       ready;
  logic       go;
  op_e        op;

  memory_array_rst_sync u_rst_sync (
    .clk   (clk),
    .reset (reset),
    .ready (ready)
  );

  assign op = op_e'(wrt_read);
  assign go = enable & ready;

  // Address decode doubles as the range check: an address >= l matches no
  // word, so reads return 0 and writes are dropped.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(l); i++) begin
      if (int'(add) == i) begin
        rd_data = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(l); i++) begin
        mem_q[i] <= '0;
      end
    end else if (go && op == OP_WRITE) begin
      for (int i = 0; i < int'(l); i++) begin
        if (int'(add) == i) begin
          mem_q[i] <= write;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= '0;
    end else if (go && op == OP_READ) begin
      out <= rd_data;
    end
  end

endmodule

// File: tb/tb_memory_array.sv
`timescale 1ns/100ps
module tb_memory_array;

  localparam int W = 7;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wrt_read = 1'b0;
  logic [W:0]   write = '0;
  logic [3:0]   add = '0;
  logic         enable = 1'b0;
  logic [W:0]   out;

  int passes = 0;
  int total  = 0;

  // Reference model: plain array of words, edge counter since reset release.
  logic [W:0] ref_mem [16];
  logic [W:0] ref_out;
  int         edges_up;
  bit         in_reset;

  memory_array #(.w(W), .l(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .wrt_read (wrt_read),
    .write    (write),
    .add      (add),
    .enable   (enable),
    .out      (out)
  );

  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_out  = '0;
    edges_up = 0;
  endfunction

  function automatic void model_edge(input bit en, input bit wr, input logic [3:0] a,
                                     input logic [W:0] d);
    if (in_reset) return;
    edges_up++;
    if (edges_up < 2 || !en) return;
    if (wr) begin
      if (int'(a) < L) ref_mem[a] = d;
    end else begin
      ref_out = (int'(a) < L) ? ref_mem[a] : '0;
    end
  endfunction

  // Drive one cycle of inputs, let one rising edge pass, compare out to the model.
  task automatic cycle(input bit en, input bit wr, input logic [3:0] a, input logic [W:0] d,
                       input string tag);
    enable   = en;
    wrt_read = wr;
    add      = a;
    write    = d;
    @(posedge clk);
    model_edge(en, wr, a, d);
    #1;
    check(tag, out, ref_out);
  endtask

  // Assert reset between edges and check the clear happens without a clock.
  task automatic pull_reset(input string tag);
    reset    = 1'b0;
    in_reset = 1'b1;
    model_clear();
    #1;
    check(tag, out, 8'h00);
  endtask

  task automatic release_reset();
    reset    = 1'b1;
    in_reset = 1'b0;
    edges_up = 0;
  endtask

  initial begin
    model_clear();
    in_reset = 1'b0;

    // 1. Reset clears out immediately; held reset ignores the port.
    #0.5;
    pull_reset("rst_async");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'($urandom), 4'($urandom), 8'($urandom), "rst_hold");
    end
    release_reset();
    for (int i = 0; i < L; i++) begin
      cycle(1'b1, 1'b0, 4'(i), 8'h00, "init_read");
    end
    check("init_read9", out, 8'h00);

    // 2. Basic writes then reads, one cycle latency.
    cycle(1'b1, 1'b1, 4'd0, 8'd10, "wr0");
    cycle(1'b1, 1'b1, 4'd3, 8'd33, "wr3");
    cycle(1'b1, 1'b1, 4'd5, 8'd66, "wr5");
    cycle(1'b1, 1'b0, 4'd0, 8'h00, "rd0");
    check("rd0_lit", out, 8'd10);
    cycle(1'b1, 1'b0, 4'd1, 8'h00, "rd1");
    check("rd1_lit", out, 8'd0);
    cycle(1'b1, 1'b0, 4'd3, 8'h00, "rd3");
    check("rd3_lit", out, 8'd33);
    cycle(1'b1, 1'b0, 4'd5, 8'h00, "rd5");
    check("rd5_lit", out, 8'd66);

    // 3. Top-of-range write/read-after-write, out-of-range write and read.
    cycle(1'b1, 1'b1, 4'd9, 8'hAA, "wr9");
    cycle(1'b1, 1'b0, 4'd9, 8'h00, "raw9");
    check("raw9_lit", out, 8'hAA);
    cycle(1'b1, 1'b1, 4'd12, 8'h55, "wr12_oor");
    cycle(1'b1, 1'b0, 4'd12, 8'h00, "rd12_oor");
    check("rd12_lit", out, 8'h00);
    cycle(1'b1, 1'b0, 4'd2, 8'h00, "rd2");
    check("rd2_lit", out, 8'h00);

    // 4. enable=0 holds memory and out.
    cycle(1'b1, 1'b0, 4'd5, 8'h00, "pre_idle");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 4'd3, 8'hFF, "idle_hold");
    end
    check("idle_out_lit", out, 8'd66);
    cycle(1'b1, 1'b0, 4'd3, 8'h00, "idle_rd3");
    check("idle_rd3_lit", out, 8'd33);

    // Randomized traffic over all addresses against the model.
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 8'($urandom), "rand");
    end

    // 5. Reset mid-sequence clears out at once and every word.
    cycle(1'b1, 1'b1, 4'd3, 8'd33, "pre_rst_wr");
    cycle(1'b1, 1'b0, 4'd3, 8'h00, "pre_rst_rd");
    check("pre_rst_lit", out, 8'd33);
    pull_reset("rst_mid");
    cycle(1'b1, 1'b0, 4'd3, 8'h00, "rst_mid_hold");
    release_reset();
    cycle(1'b0, 1'b0, 4'd0, 8'h00, "rel_idle0");
    cycle(1'b0, 1'b0, 4'd0, 8'h00, "rel_idle1");
    cycle(1'b1, 1'b0, 4'd0, 8'h00, "post_rd0");
    cycle(1'b1, 1'b0, 4'd3, 8'h00, "post_rd3");
    check("post_rd3_lit", out, 8'h00);
    cycle(1'b1, 1'b0, 4'd5, 8'h00, "post_rd5");
    check("post_rd5_lit", out, 8'h00);

    // 6. First edge after release is ignored, second edge acts.
    cycle(1'b1, 1'b1, 4'd6, 8'h5A, "seed6");
    pull_reset("rst_again");
    release_reset();
    cycle(1'b1, 1'b1, 4'd4, 8'h77, "edge1_wr");
    cycle(1'b1, 1'b1, 4'd6, 8'h88, "edge2_wr");
    cycle(1'b1, 1'b0, 4'd4, 8'h00, "edge1_rd4");
    check("edge1_lit", out, 8'h00);
    cycle(1'b1, 1'b0, 4'd6, 8'h00, "edge2_rd6");
    check("edge2_lit", out, 8'h88);
    pull_reset("rst_rd_edge");
    release_reset();
    cycle(1'b1, 1'b0, 4'd6, 8'h00, "edge1_rd");
    cycle(1'b1, 1'b1, 4'd7, 8'h3C, "edge2_wr7");
    cycle(1'b1, 1'b0, 4'd7, 8'h00, "edge3_rd7");
    check("edge3_lit", out, 8'h3C);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
